// File: rtl/jtag_dr_ir_controller.sv
// JTAG IR/DR data path behind the TAP: IR, IDCODE, BYPASS and USER chains with capture/shift/update.
// Optional sticky illegal-state detection is enabled by defining JTAG_ILLEGAL_STATE_CHECK_EN.
module jtag_dr_ir_controller #(
    parameter int                  IR_WIDTH      = 4,
    parameter logic [31:0]         IDCODE_VALUE  = 32'h1000_563D,
    parameter int                  USER_DR_WIDTH = 8,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE  = IR_WIDTH'(4'h1),
    parameter logic [IR_WIDTH-1:0] INSTR_USER    = IR_WIDTH'(4'h8)
) (
    input  logic                     tck,
    input  logic                     trst,
    input  logic                     tdi,
    input  logic [4:0]               tap_state,
    input  logic [USER_DR_WIDTH-1:0] user_dr_in,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [IR_WIDTH-1:0]      ir_value,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic                     user_update,
    output logic                     err_illegal_state
);

    typedef enum logic [4:0] {
        TEST_LOGIC_RESET = 5'h00,
        RUN_TEST_IDLE    = 5'h01,
        SELECT_DR_SCAN   = 5'h02,
        SELECT_IR_SCAN   = 5'h03,
        CAPTURE_DR       = 5'h04,
        CAPTURE_IR       = 5'h05,
        SHIFT_DR         = 5'h06,
        SHIFT_IR         = 5'h07,
        EXIT1_DR         = 5'h08,
        EXIT1_IR         = 5'h09,
        PAUSE_DR         = 5'h10,
        PAUSE_IR         = 5'h11,
        EXIT2_DR         = 5'h12,
        EXIT2_IR         = 5'h13,
        UPDATE_DR        = 5'h14,
        UPDATE_IR        = 5'h15
    } tap_state_e;

    tap_state_e                 state;
    logic [IR_WIDTH-1:0]        ir_shift;
    logic [31:0]                idcode_shift;
    logic                       bypass_reg;
    logic [USER_DR_WIDTH-1:0]   user_shift;
    logic [USER_DR_WIDTH-1:0]   user_shift_next;
    logic                       sel_idcode;
    logic                       sel_user;

    assign state      = tap_state_e'(tap_state);
    assign sel_idcode = (ir_value == INSTR_IDCODE);
    assign sel_user   = (ir_value == INSTR_USER);
    assign tdo_en     = (state == SHIFT_IR) || (state == SHIFT_DR);

    // Written this way so a one-bit USER chain needs no special case.
    always_comb begin
        user_shift_next                    = user_shift >> 1;
        user_shift_next[USER_DR_WIDTH-1]   = tdi;
    end

    // Illegal codes fall into the default arm, so every register simply holds.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_value     <= INSTR_IDCODE;
            ir_shift     <= '0;
            idcode_shift <= IDCODE_VALUE;
            bypass_reg   <= 1'b0;
            user_shift   <= '0;
            user_dr_out  <= '0;
            user_update  <= 1'b0;
        end else begin
            user_update <= 1'b0;
            case (state)
                TEST_LOGIC_RESET: ir_value <= INSTR_IDCODE;
                CAPTURE_IR:       ir_shift <= IR_WIDTH'(2'b01);
                SHIFT_IR:         ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_value <= ir_shift;
                CAPTURE_DR: begin
                    if (sel_idcode)    idcode_shift <= IDCODE_VALUE;
                    else if (sel_user) user_shift   <= user_dr_in;
                    else               bypass_reg   <= 1'b0;
                end
                SHIFT_DR: begin
                    bypass_reg <= tdi;
                    if (sel_idcode)    idcode_shift <= {tdi, idcode_shift[31:1]};
                    else if (sel_user) user_shift   <= user_shift_next;
                end
                UPDATE_DR: begin
                    if (sel_user) begin
                        user_dr_out <= user_shift;
                        user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // tdo is forced low during trst so a reset mid-shift silences the pin at once.
    always_comb begin
        tdo = 1'b0;
        if (!trst) begin
            case (state)
                SHIFT_IR: tdo = ir_shift[0];
                SHIFT_DR: tdo = sel_idcode ? idcode_shift[0] :
                                sel_user   ? user_shift[0]   : bypass_reg;
                default:  tdo = 1'b0;
            endcase
        end
    end

`ifdef JTAG_ILLEGAL_STATE_CHECK_EN
    logic state_illegal;

    assign state_illegal = (tap_state inside {[5'h0A:5'h0F], [5'h16:5'h1F]});

    always_ff @(posedge tck or posedge trst) begin
        if (trst)               err_illegal_state <= 1'b0;
        else if (state_illegal) err_illegal_state <= 1'b1;
    end
`else
    assign err_illegal_state = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_dr_ir_controller.sv
// Self-checking bench for jtag_dr_ir_controller using a queue-based reference model of the scan chains.
// Honours JTAG_ILLEGAL_STATE_CHECK_EN when deciding what err_illegal_state should read.
module tb_jtag_dr_ir_controller;

    localparam int          IRW = 4;
    localparam int          UW  = 8;
    localparam logic [31:0] IDC = 32'h1000_563D;
`ifdef JTAG_ILLEGAL_STATE_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           tck = 1'b0;
    logic           trst;
    logic           tdi;
    logic [4:0]     tap_state;
    logic [UW-1:0]  user_dr_in;
    logic           tdo;
    logic           tdo_en;
    logic [IRW-1:0] ir_value;
    logic [UW-1:0]  user_dr_out;
    logic           user_update;
    logic           err_illegal_state;

    int tests_run    = 0;
    int tests_failed = 0;

    jtag_dr_ir_controller dut (
        .tck               (tck),
        .trst              (trst),
        .tdi               (tdi),
        .tap_state         (tap_state),
        .user_dr_in        (user_dr_in),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .ir_value          (ir_value),
        .user_dr_out       (user_dr_out),
        .user_update       (user_update),
        .err_illegal_state (err_illegal_state)
    );

    always #5 tck = ~tck;

    // Reference model: each chain is a bit queue, front = bit that appears on tdo next.
    logic [IRW-1:0] m_ir;
    logic           m_ir_q[$];
    logic           m_id_q[$];
    logic           m_user_q[$];
    logic           m_byp;
    logic [UW-1:0]  m_user_out;
    logic           m_upd;
    logic           m_err;

    task automatic model_reset();
        m_ir = 4'h1;
        m_ir_q.delete();
        for (int i = 0; i < IRW; i++) m_ir_q.push_back(1'b0);
        m_id_q.delete();
        for (int i = 0; i < 32; i++) m_id_q.push_back(IDC[i]);
        m_user_q.delete();
        for (int i = 0; i < UW; i++) m_user_q.push_back(1'b0);
        m_byp      = 1'b0;
        m_user_out = '0;
        m_upd      = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] st, input logic t, input logic [UW-1:0] udr,
                              output logic exp_tdo);
        logic out_bit;
        exp_tdo = 1'b0;
        if (st == 5'h07) exp_tdo = m_ir_q[0];
        if (st == 5'h06) exp_tdo = (m_ir == 4'h1) ? m_id_q[0] : (m_ir == 4'h8) ? m_user_q[0] : m_byp;
        m_upd = 1'b0;
        case (st)
            5'h00: m_ir = 4'h1;
            5'h05: begin
                m_ir_q.delete();
                m_ir_q.push_back(1'b1);
                for (int i = 1; i < IRW; i++) m_ir_q.push_back(1'b0);
            end
            5'h07: begin
                out_bit = m_ir_q.pop_front();
                m_ir_q.push_back(t);
            end
            5'h15: for (int i = 0; i < IRW; i++) m_ir[i] = m_ir_q[i];
            5'h04: begin
                if (m_ir == 4'h1) begin
                    m_id_q.delete();
                    for (int i = 0; i < 32; i++) m_id_q.push_back(IDC[i]);
                end else if (m_ir == 4'h8) begin
                    m_user_q.delete();
                    for (int i = 0; i < UW; i++) m_user_q.push_back(udr[i]);
                end else begin
                    m_byp = 1'b0;
                end
            end
            5'h06: begin
                if (m_ir == 4'h1) begin
                    out_bit = m_id_q.pop_front();
                    m_id_q.push_back(t);
                end else if (m_ir == 4'h8) begin
                    out_bit = m_user_q.pop_front();
                    m_user_q.push_back(t);
                end
                m_byp = t;
            end
            5'h14: begin
                if (m_ir == 4'h8) begin
                    for (int i = 0; i < UW; i++) m_user_out[i] = m_user_q[i];
                    m_upd = 1'b1;
                end
            end
            default: begin
                if ((st >= 5'h0A && st <= 5'h0F) || st >= 5'h16) m_err = 1'b1;
            end
        endcase
    endtask

    // Drives one tck cycle; combinational outputs are sampled mid-low-phase, before the edge acts.
    task automatic applyStimulus(input logic [4:0] st, input logic t, input logic [UW-1:0] udr,
                                 output logic obs_tdo, output logic obs_en);
        @(negedge tck);
        tap_state  = st;
        tdi        = t;
        user_dr_in = udr;
        #1;
        obs_tdo = tdo;
        obs_en  = tdo_en;
        @(posedge tck);
        #1;
    endtask

    task automatic run_cycle(input logic [4:0] st, input logic t, input logic [UW-1:0] udr,
                             output logic exp_tdo, output logic obs_tdo, output logic obs_en);
        model_step(st, t, udr, exp_tdo);
        applyStimulus(st, t, udr, obs_tdo, obs_en);
    endtask

    task automatic test_reset();
        trst = 1'b1; tap_state = 5'h00; tdi = 1'b0; user_dr_in = '0;
        #12;
        model_reset();
        tests_run++;
        if (ir_value !== 4'h1) begin tests_failed++; $display("[TB] FAIL reset_ir_value got %h want 1", ir_value); end
        tests_run++;
        if (user_dr_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_user_dr_out got %h want 00", user_dr_out); end
        tests_run++;
        if (user_update !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_user_update got %b want 0", user_update); end
        tests_run++;
        if (err_illegal_state !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", err_illegal_state); end
        tests_run++;
        if (tdo !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tdo got %b want 0", tdo); end
        @(negedge tck);
        trst = 1'b0;
    endtask

    task automatic test_idcode();
        logic e, o, en;
        logic [31:0] word;
        run_cycle(5'h00, 1'b0, '0, e, o, en);
        run_cycle(5'h01, 1'b0, '0, e, o, en);
        run_cycle(5'h02, 1'b0, '0, e, o, en);
        run_cycle(5'h04, 1'b0, '0, e, o, en);
        for (int i = 0; i < 32; i++) begin
            run_cycle(5'h06, 1'b0, '0, e, o, en);
            word[i] = o;
            tests_run++;
            if (o !== e || en !== 1'b1) begin tests_failed++; $display("[TB] FAIL idcode_bit%0d got tdo=%b en=%b want tdo=%b en=1", i, o, en, e); end
            tests_run++;
            if (ir_value !== 4'h1) begin tests_failed++; $display("[TB] FAIL idcode_ir_value got %h want 1", ir_value); end
        end
        tests_run++;
        if (word !== 32'h1000_563D) begin tests_failed++; $display("[TB] FAIL idcode_word got %h want 1000563d", word); end
    endtask

    task automatic test_ir_scan();
        logic e, o, en;
        logic [3:0] nib;
        run_cycle(5'h01, 1'b0, '0, e, o, en);
        run_cycle(5'h02, 1'b0, '0, e, o, en);
        run_cycle(5'h03, 1'b0, '0, e, o, en);
        run_cycle(5'h05, 1'b0, '0, e, o, en);
        for (int i = 0; i < 4; i++) begin
            run_cycle(5'h07, 1'b1, '0, e, o, en);
            nib[i] = o;
            tests_run++;
            if (o !== e || en !== 1'b1) begin tests_failed++; $display("[TB] FAIL ir_shift_bit%0d got tdo=%b en=%b want tdo=%b en=1", i, o, en, e); end
        end
        tests_run++;
        if (nib !== 4'b0001) begin tests_failed++; $display("[TB] FAIL ir_capture_pattern got %b want 0001", nib); end
        run_cycle(5'h09, 1'b0, '0, e, o, en);
        run_cycle(5'h15, 1'b0, '0, e, o, en);
        tests_run++;
        if (ir_value !== 4'hF || ir_value !== m_ir) begin tests_failed++; $display("[TB] FAIL ir_update got %h want f", ir_value); end
    endtask

    task automatic test_bypass();
        logic e, o, en;
        logic [4:0] pattern = 5'b01101;
        logic [4:0] stream;
        run_cycle(5'h01, 1'b0, '0, e, o, en);
        run_cycle(5'h02, 1'b0, '0, e, o, en);
        run_cycle(5'h04, 1'b0, '0, e, o, en);
        for (int i = 0; i < 5; i++) begin
            run_cycle(5'h06, pattern[i], '0, e, o, en);
            stream[i] = o;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL bypass_bit%0d got %b want %b", i, o, e); end
        end
        tests_run++;
        if (stream !== 5'b11010) begin tests_failed++; $display("[TB] FAIL bypass_stream got %b want 11010", stream); end
        run_cycle(5'h08, 1'b0, '0, e, o, en);
        run_cycle(5'h14, 1'b0, '0, e, o, en);
        tests_run++;
        if (user_update !== 1'b0) begin tests_failed++; $display("[TB] FAIL bypass_no_update got %b want 0", user_update); end
    endtask

    task automatic test_user();
        logic e, o, en;
        logic [3:0]    op = 4'h8;
        logic [UW-1:0] cap, sh, stream;
        run_cycle(5'h05, 1'b0, '0, e, o, en);
        for (int i = 0; i < 4; i++) run_cycle(5'h07, op[i], '0, e, o, en);
        run_cycle(5'h15, 1'b0, '0, e, o, en);
        tests_run++;
        if (ir_value !== 4'h8) begin tests_failed++; $display("[TB] FAIL user_ir_load got %h want 8", ir_value); end
        for (int k = 0; k < 4; k++) begin
            cap = (k == 0) ? 8'hA5 : 8'($urandom);
            sh  = (k == 0) ? 8'h3C : 8'($urandom);
            run_cycle(5'h04, 1'b0, cap, e, o, en);
            for (int i = 0; i < UW; i++) begin
                run_cycle(5'h06, sh[i], cap, e, o, en);
                stream[i] = o;
                tests_run++;
                if (o !== e) begin tests_failed++; $display("[TB] FAIL user_shift_bit%0d got %b want %b", i, o, e); end
            end
            tests_run++;
            if (stream !== cap) begin tests_failed++; $display("[TB] FAIL user_capture got %h want %h", stream, cap); end
            run_cycle(5'h08, 1'b0, cap, e, o, en);
            tests_run++;
            if (user_update !== 1'b0) begin tests_failed++; $display("[TB] FAIL user_update_early got %b want 0", user_update); end
            run_cycle(5'h14, 1'b0, cap, e, o, en);
            tests_run++;
            if (user_dr_out !== sh || user_dr_out !== m_user_out) begin tests_failed++; $display("[TB] FAIL user_dr_out got %h want %h", user_dr_out, sh); end
            tests_run++;
            if (user_update !== 1'b1) begin tests_failed++; $display("[TB] FAIL user_update_pulse got %b want 1", user_update); end
            run_cycle(5'h01, 1'b0, cap, e, o, en);
            tests_run++;
            if (user_update !== 1'b0) begin tests_failed++; $display("[TB] FAIL user_update_width got %b want 0", user_update); end
        end
    endtask

    task automatic test_trst_mid_shift();
        logic e, o, en;
        run_cycle(5'h02, 1'b0, '0, e, o, en);
        run_cycle(5'h04, 1'b0, 8'($urandom), e, o, en);
        for (int i = 0; i < 3; i++) begin
            run_cycle(5'h06, 1'($urandom), '0, e, o, en);
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL trst_pre_bit%0d got %b want %b", i, o, e); end
        end
        @(negedge tck);
        tap_state = 5'h06;
        #2;
        trst = 1'b1;
        #1;
        tests_run++;
        if (ir_value !== 4'h1) begin tests_failed++; $display("[TB] FAIL trst_ir_value got %h want 1", ir_value); end
        tests_run++;
        if (user_dr_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL trst_user_dr_out got %h want 00", user_dr_out); end
        tests_run++;
        if (tdo !== 1'b0) begin tests_failed++; $display("[TB] FAIL trst_tdo got %b want 0", tdo); end
        model_reset();
        @(negedge tck);
        trst      = 1'b0;
        tap_state = 5'h01;
    endtask

    task automatic test_illegal_state();
        logic e, o, en;
        run_cycle(5'h02, 1'b0, '0, e, o, en);
        run_cycle(5'h04, 1'b0, '0, e, o, en);
        for (int i = 0; i < 5; i++) run_cycle(5'h06, 1'($urandom), '0, e, o, en);
        run_cycle(5'h0B, 1'b1, '0, e, o, en);
        tests_run++;
        if (o !== 1'b0 || en !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_outputs got tdo=%b en=%b want 0 0", o, en); end
        tests_run++;
        if (err_illegal_state !== ERR_EN) begin tests_failed++; $display("[TB] FAIL illegal_err got %b want %b", err_illegal_state, ERR_EN); end
        for (int i = 0; i < 8; i++) begin
            run_cycle(5'h06, 1'($urandom), '0, e, o, en);
            tests_run++;
            if (o !== e) begin tests_failed++; $display("[TB] FAIL illegal_hold_bit%0d got %b want %b", i, o, e); end
        end
        tests_run++;
        if (err_illegal_state !== ERR_EN || ir_value !== 4'h1) begin tests_failed++; $display("[TB] FAIL illegal_sticky got err=%b ir=%h want err=%b ir=1", err_illegal_state, ir_value, ERR_EN); end
    endtask

    task automatic test_random();
        logic e, o, en;
        logic [4:0] st;
        logic [4:0] legal_codes [16] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                         5'h08, 5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15};
        @(negedge tck);
        trst = 1'b1;
        #2;
        model_reset();
        tests_run++;
        if (err_illegal_state !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_err_clear got %b want 0", err_illegal_state); end
        @(negedge tck);
        trst      = 1'b0;
        tap_state = 5'h01;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0)
                st = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(10, 15)) : 5'($urandom_range(22, 31));
            else
                st = legal_codes[$urandom_range(0, 15)];
            run_cycle(st, 1'($urandom), 8'($urandom), e, o, en);
            tests_run++;
            if (o !== e || en !== (st == 5'h06 || st == 5'h07)) begin tests_failed++; $display("[TB] FAIL rand_tdo st=%h got tdo=%b en=%b want tdo=%b", st, o, en, e); end
            tests_run++;
            if (ir_value !== m_ir || user_dr_out !== m_user_out) begin tests_failed++; $display("[TB] FAIL rand_regs got ir=%h dr=%h want ir=%h dr=%h", ir_value, user_dr_out, m_ir, m_user_out); end
            tests_run++;
            if (user_update !== m_upd || err_illegal_state !== (ERR_EN & m_err)) begin tests_failed++; $display("[TB] FAIL rand_flags got upd=%b err=%b want upd=%b err=%b", user_update, err_illegal_state, m_upd, ERR_EN & m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_ir_scan();
        test_bypass();
        test_user();
        test_trst_mid_shift();
        test_illegal_state();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
